// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
//
// 8N1 UART receiver (LSB first, idle-high line) feeding a small
// first-word-fall-through receive FIFO.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (8..65535)
//   FIFO_DEPTH   : receive FIFO entries, power of two (2..16)
//
// Ports
//   clk       in   single rising-edge clock
//   rst       in   synchronous active-high reset
//   rx        in   asynchronous UART line
//   m_data    out  byte at FIFO head (0x00 while empty)
//   m_valid   out  FIFO non-empty
//   m_ready   in   consumer takes the head when m_valid & m_ready
//   frame_err out  one-cycle pulse when a stop bit is sampled low
//   overrun   out  one-cycle pulse when a good byte is dropped (FIFO full)
//   busy      out  receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer; both stages idle high so reset looks like an
    // idle line.
    // -----------------------------------------------------------------------
    logic sync1_reg;
    logic rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync1_reg <= rx;
            rx_s      <= sync1_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic        stop_good;
    logic        stop_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 16'd0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                cnt_next = 16'd0;
                bit_next = 3'd0;
                if (!rx_s) begin
                    state_next = S_START;
                end
            end

            // Re-check the start bit at its centre; a high line here means
            // the falling edge was a glitch and is silently dropped.
            S_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = 16'd0;
                    bit_next   = 3'd0;
                    state_next = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            // Shift right so the first (LSB) bit ends up in bit 0 after 8.
            S_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = 16'd0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            S_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = 16'd0;
                    if (rx_s) begin
                        stop_good  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            // A break keeps the line low; wait it out so it yields only one
            // frame error instead of a stream of bogus frames.
            S_WAIT_HIGH: begin
                cnt_next = 16'd0;
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != S_IDLE);
    assign frame_err = stop_bad & ~rst;

    // -----------------------------------------------------------------------
    // Receive FIFO: pointers carry one extra wrap bit so full and empty are
    // distinguishable without a separate count.
    // -----------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        push_ok;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop      = m_valid & m_ready;
    assign push_req = stop_good & ~rst;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign push_ok  = push_req & (~full | pop);
    assign overrun  = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    assign m_valid = ~empty;
    // Storage is not reset, so present zero while nothing is queued.
    assign m_data  = m_valid ? mem[rd_ptr_reg[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_byte_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_rx
//
// Self-checking bench for uart_byte_rx (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// The line is driven from a per-cycle queue of levels. Each frame queued
// also schedules, from bit-timing arithmetic, the clock edge at which the
// receiver samples its stop bit and the window during which it is busy.
// A queue-based FIFO model then predicts m_valid/m_data/frame_err/overrun/
// busy every cycle.
// ---------------------------------------------------------------------------
module tb_uart_byte_rx;

    localparam int C     = 16;
    localparam int HALF  = C / 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_byte_rx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        bit         is_push;
        logic [7:0] data;
    } evt_t;

    typedef struct {
        int lo;
        int hi;
    } span_t;

    bit         line_q[$];
    evt_t       evt_q[$];
    span_t      busy_q[$];
    logic [7:0] fifo_q[$];

    int cyc        = 0;
    int checks     = 0;
    int failures   = 0;
    int ready_mode = 0;   // 0 low, 1 high, 2 random, 3 pulse at pulse_edge
    int pulse_edge = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance model
    // to the state after the coming rising edge (edge number cyc+1).
    task automatic step();
        int         ne;
        bit         exp_valid;
        bit         exp_busy;
        bit         exp_ferr;
        bit         exp_ovr;
        bit         do_pop;
        bit         do_push;
        logic [7:0] push_data;

        if (line_q.size() > 0) rx = line_q.pop_front();
        else                   rx = 1'b1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = (cyc + 1 == pulse_edge);
        endcase

        @(negedge clk);
        ne        = cyc + 1;
        exp_valid = (fifo_q.size() > 0);
        exp_busy  = 1'b0;
        foreach (busy_q[i]) begin
            if (cyc >= busy_q[i].lo && cyc < busy_q[i].hi) exp_busy = 1'b1;
        end
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        do_push   = 1'b0;
        push_data = 8'h00;
        do_pop    = exp_valid && m_ready && !rst;
        if (!rst) begin
            foreach (evt_q[i]) begin
                if (evt_q[i].edge_n == ne) begin
                    if (!evt_q[i].is_push) begin
                        exp_ferr = 1'b1;
                    end else if (fifo_q.size() < DEPTH || do_pop) begin
                        do_push   = 1'b1;
                        push_data = evt_q[i].data;
                    end else begin
                        exp_ovr = 1'b1;
                        $display("drop data=%02h (overrun) cyc=%0d", evt_q[i].data, cyc);
                    end
                end
            end
        end

        check("m_valid", 32'(m_valid), 32'(exp_valid));
        if (exp_valid) check("m_data", 32'(m_data), 32'(fifo_q[0]));
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("busy", 32'(busy), 32'(exp_busy));

        if (exp_ferr) $display("frame error cyc=%0d", cyc);

        if (rst) begin
            fifo_q.delete();
            evt_q.delete();
            foreach (busy_q[i]) begin
                if (busy_q[i].hi > ne) busy_q[i].hi = ne;
            end
        end else begin
            if (do_pop) begin
                $display("pop data=%02h cyc=%0d", fifo_q[0], cyc);
                void'(fifo_q.pop_front());
            end
            if (do_push) fifo_q.push_back(push_data);
        end
        while (evt_q.size() > 0 && evt_q[0].edge_n <= ne) void'(evt_q.pop_front());
        while (busy_q.size() > 0 && busy_q[0].hi <= ne) void'(busy_q.pop_front());

        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Frame: start, 8 data bits LSB first, stop; each bit C cycles.
    // Receiver goes busy two edges after the start bit reaches the pins
    // (synchronizer), samples the start bit HALF edges later and each
    // following bit C edges after that.
    task automatic add_frame(input logic [7:0] b, input bit stop_ok,
                             input int extra_low, output int es);
        int    e0;
        evt_t  ev;
        span_t sp;
        e0 = cyc + 1 + line_q.size();
        repeat (C) line_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (C) line_q.push_back(b[i]);
        end
        repeat (C) line_q.push_back(stop_ok);
        es         = e0 + 2 + HALF + 9 * C;
        ev.edge_n  = es;
        ev.is_push = stop_ok;
        ev.data    = b;
        evt_q.push_back(ev);
        sp.lo = e0 + 2;
        if (stop_ok) begin
            sp.hi = es;
        end else begin
            repeat (extra_low) line_q.push_back(1'b0);
            // Idle again two edges after the line returns high.
            sp.hi = e0 + 10 * C + extra_low + 2;
            repeat (3) line_q.push_back(1'b1);
        end
        busy_q.push_back(sp);
    endtask

    task automatic add_glitch(input int len);
        int    g;
        span_t sp;
        g = cyc + 1 + line_q.size();
        repeat (len) line_q.push_back(1'b0);
        repeat (HALF + 2) line_q.push_back(1'b1);
        sp.lo = g + 2;
        sp.hi = g + 2 + HALF;
        busy_q.push_back(sp);
    endtask

    task automatic add_idle(input int n);
        repeat (n) line_q.push_back(1'b1);
    endtask

    task automatic run_line(input int tail);
        while (line_q.size() > 0) step();
        repeat (tail) step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int es;
        int e0;
        int target;
        int r;

        // Reset
        rst = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1;
        step();
        step();
        check("rst_m_data", 32'(m_data), 32'h00);
        rst = 1'b0;
        add_idle(4);
        run_line(0);

        // Back-to-back frames, consumer always ready
        ready_mode = 1;
        add_frame(8'h55, 1'b1, 0, es);
        add_frame(8'hA3, 1'b1, 0, es);
        run_line(5);

        // Short low glitch on an idle line
        add_glitch(4);
        run_line(5);

        // Break: bad stop bit, line kept low, then a good byte
        add_frame(8'h3C, 1'b0, 40, es);
        add_frame(8'h12, 1'b1, 0, es);
        run_line(5);

        // Overrun on the fifth byte, then drain
        ready_mode = 0;
        for (int i = 1; i <= 5; i++) add_frame(8'(i), 1'b1, 0, es);
        run_line(5);
        ready_mode = 1;
        repeat (10) step();

        // Full FIFO with a pop exactly in the stop-sample cycle
        ready_mode = 0;
        add_frame(8'h11, 1'b1, 0, es);
        add_frame(8'h22, 1'b1, 0, es);
        add_frame(8'h33, 1'b1, 0, es);
        add_frame(8'h44, 1'b1, 0, es);
        add_frame(8'h77, 1'b1, 0, es);
        pulse_edge = es;
        ready_mode = 3;
        run_line(5);
        ready_mode = 1;
        repeat (10) step();

        // Reset in the middle of a frame while a byte is queued
        ready_mode = 0;
        add_frame(8'hAB, 1'b1, 0, es);
        run_line(3);
        add_frame(8'hF0, 1'b1, 0, es);
        e0     = es - 2 - HALF - 9 * C;
        target = e0 + 2 + HALF + 3 * C + C / 2;
        while (cyc + 1 < target) step();
        rst = 1'b1;
        line_q.delete();
        step();
        step();
        rst = 1'b0;
        add_idle(5);
        run_line(0);
        ready_mode = 1;
        add_frame(8'h9E, 1'b1, 0, es);
        run_line(5);

        // Random mix of frames, glitches and breaks with a random consumer
        ready_mode = 2;
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      add_frame(8'($urandom_range(0, 255)), 1'b1, 0, es);
            else if (r < 85) add_glitch(int'($urandom_range(1, HALF - 1)));
            else             add_frame(8'($urandom_range(0, 255)), 1'b0,
                                       int'($urandom_range(0, 30)), es);
            if ($urandom_range(0, 1) == 1) add_idle(int'($urandom_range(1, 12)));
        end
        run_line(5);
        ready_mode = 1;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
